// File: rtl/wishbone_sram_slave.sv
// ---------------------------------------------------------------------------
// wishbone_sram_slave
//
// Wishbone classic-cycle responder in front of a 32-bit asynchronous SRAM.
// Each accepted transfer asserts the SRAM strobes for a programmable number
// of wait cycles and then returns a single-cycle registered ack. Byte lanes
// come from wb_sel_i through sram_be_n.
//
// Handshake: a transfer is requested while wb_cyc_i & wb_stb_i are high in
// IDLE, and its address, data, select and direction are captured at that
// edge. wb_ack_o is high for exactly one cycle per completed transfer. The
// next request is accepted only from IDLE, which is always at least one
// cycle after the ack cycle. If wb_stb_i is still high then, that is a new
// transfer. Dropping wb_cyc_i during the wait cycles abandons the transfer
// with no ack.
//
// Parameters
//   ADDR_WIDTH  SRAM word-address width (word = wb_addr_i[ADDR_WIDTH+1:2])
//   READ_WAIT   cycles sram_oe_n is held low before data is sampled (>=1)
//   WRITE_WAIT  cycles sram_we_n is held low per write (>=1)
//
// Ports
//   clk, rst          clock, synchronous active-high reset
//   wb_cyc_i/stb_i    bus cycle / strobe
//   wb_we_i           1 = write, 0 = read
//   wb_addr_i         byte address (bits [1:0] ignored)
//   wb_data_i         write data
//   wb_sel_i          byte lane enables
//   wb_data_o         read data, held until the next read completes
//   wb_ack_o          one-cycle transfer acknowledge
//   sram_addr_o       SRAM word address
//   sram_data_i/o     SRAM data bus in / out
//   sram_data_oe      1 = drive sram_data_o onto the pins
//   sram_ce_n/oe_n/we_n/be_n   active-low SRAM controls
//   dbg_state         current FSM state (IDLE=0 READ=1 WRITE=2 HOLD=3 ACK=4)
// ---------------------------------------------------------------------------
module wishbone_sram_slave #(
  parameter int ADDR_WIDTH = 20,
  parameter int READ_WAIT  = 2,
  parameter int WRITE_WAIT = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  wb_cyc_i,
  input  logic                  wb_stb_i,
  input  logic                  wb_we_i,
  input  logic [31:0]           wb_addr_i,
  input  logic [31:0]           wb_data_i,
  input  logic [3:0]            wb_sel_i,
  output logic [31:0]           wb_data_o,
  output logic                  wb_ack_o,
  output logic [ADDR_WIDTH-1:0] sram_addr_o,
  input  logic [31:0]           sram_data_i,
  output logic [31:0]           sram_data_o,
  output logic                  sram_data_oe,
  output logic                  sram_ce_n,
  output logic                  sram_oe_n,
  output logic                  sram_we_n,
  output logic [3:0]            sram_be_n,
  output logic [2:0]            dbg_state
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_READ  = 3'd1,
    S_WRITE = 3'd2,
    S_HOLD  = 3'd3,
    S_ACK   = 3'd4
  } state_t;

  localparam int MAX_WAIT = (READ_WAIT > WRITE_WAIT) ? READ_WAIT : WRITE_WAIT;
  localparam int CW       = $clog2(MAX_WAIT) + 1;

  // Counter loads wait-1 and counts down to zero, so a phase lasts exactly
  // WAIT cycles and the counter never wraps.
  localparam logic [CW-1:0] RD_LOAD = CW'(READ_WAIT - 1);
  localparam logic [CW-1:0] WR_LOAD = CW'(WRITE_WAIT - 1);

  state_t          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;

  logic [31:0]           rdata_d;
  logic                  ack_d;
  logic [ADDR_WIDTH-1:0] addr_d;
  logic [31:0]           wdata_d;
  logic                  data_oe_d;
  logic                  ce_n_d;
  logic                  oe_n_d;
  logic                  we_n_d;
  logic [3:0]            be_n_d;

  logic req;
  logic cnt_zero;

  assign req       = wb_cyc_i & wb_stb_i;
  assign cnt_zero  = (cnt_q == '0);
  assign dbg_state = state_q;

  // -------------------------------------------------------------------------
  // State and output registers
  // -------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_IDLE;
      cnt_q        <= '0;
      wb_data_o    <= '0;
      wb_ack_o     <= 1'b0;
      sram_addr_o  <= '0;
      sram_data_o  <= '0;
      sram_data_oe <= 1'b0;
      sram_ce_n    <= 1'b1;
      sram_oe_n    <= 1'b1;
      sram_we_n    <= 1'b1;
      sram_be_n    <= 4'b1111;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      wb_data_o    <= rdata_d;
      wb_ack_o     <= ack_d;
      sram_addr_o  <= addr_d;
      sram_data_o  <= wdata_d;
      sram_data_oe <= data_oe_d;
      sram_ce_n    <= ce_n_d;
      sram_oe_n    <= oe_n_d;
      sram_we_n    <= we_n_d;
      sram_be_n    <= be_n_d;
    end
  end

  // -------------------------------------------------------------------------
  // Next-state logic
  // -------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (req) state_d = wb_we_i ? S_WRITE : S_READ;
      end
      S_READ: begin
        // An abandoned cycle wins over completion, even in the last wait cycle.
        if (!wb_cyc_i)     state_d = S_IDLE;
        else if (cnt_zero) state_d = S_ACK;
      end
      S_WRITE: begin
        if (!wb_cyc_i)     state_d = S_IDLE;
        else if (cnt_zero) state_d = S_HOLD;
      end
      S_HOLD:  state_d = S_IDLE;
      S_ACK:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // -------------------------------------------------------------------------
  // Output logic: next values for the registered outputs
  // -------------------------------------------------------------------------
  always_comb begin
    cnt_d     = cnt_q;
    rdata_d   = wb_data_o;
    ack_d     = 1'b0;             // ack is only ever a single-cycle pulse
    addr_d    = sram_addr_o;
    wdata_d   = sram_data_o;
    data_oe_d = sram_data_oe;
    ce_n_d    = sram_ce_n;
    oe_n_d    = sram_oe_n;
    we_n_d    = sram_we_n;
    be_n_d    = sram_be_n;

    case (state_q)
      S_IDLE: begin
        if (req) begin
          addr_d  = wb_addr_i[ADDR_WIDTH+1:2];
          wdata_d = wb_data_i;
          be_n_d  = ~wb_sel_i;
          ce_n_d  = 1'b0;
          if (wb_we_i) begin
            we_n_d    = 1'b0;
            data_oe_d = 1'b1;
            cnt_d     = WR_LOAD;
          end else begin
            oe_n_d = 1'b0;
            cnt_d  = RD_LOAD;
          end
        end
      end

      S_READ: begin
        if (!wb_cyc_i) begin
          ce_n_d    = 1'b1;
          oe_n_d    = 1'b1;
          we_n_d    = 1'b1;
          be_n_d    = 4'b1111;
          data_oe_d = 1'b0;
        end else if (cnt_zero) begin
          // SRAM output has been enabled for READ_WAIT cycles: sample now.
          rdata_d = sram_data_i;
          ack_d   = 1'b1;
          oe_n_d  = 1'b1;
          ce_n_d  = 1'b1;
          be_n_d  = 4'b1111;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end

      S_WRITE: begin
        if (!wb_cyc_i) begin
          ce_n_d    = 1'b1;
          oe_n_d    = 1'b1;
          we_n_d    = 1'b1;
          be_n_d    = 4'b1111;
          data_oe_d = 1'b0;
        end else if (cnt_zero) begin
          // Raise we_n first while address, data and lanes stay put, so the
          // SRAM sees a clean hold time on the rising write strobe.
          we_n_d = 1'b1;
          ack_d  = 1'b1;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end

      S_HOLD: begin
        ce_n_d    = 1'b1;
        data_oe_d = 1'b0;
        be_n_d    = 4'b1111;
      end

      S_ACK: begin
        // Nothing to do: strobes already released on the way in.
      end

      default: begin
        ce_n_d    = 1'b1;
        oe_n_d    = 1'b1;
        we_n_d    = 1'b1;
        be_n_d    = 4'b1111;
        data_oe_d = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_wishbone_sram_slave.sv
// ---------------------------------------------------------------------------
// tb_wishbone_sram_slave
//
// Two instances: dut_a with READ_WAIT=WRITE_WAIT=2 and dut_b with both waits
// set to 1. They share the wishbone data/address/strobe signals but have
// separate wb_cyc_i, so only the selected one ever sees a request. Each has
// its own behavioural SRAM model and its own reference memory.
// ---------------------------------------------------------------------------
module tb_wishbone_sram_slave;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst;
  logic mem_init;
  int   cyc_cnt = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

  // ---------------- shared bus drive ----------------
  logic        cyc_a, cyc_b, stb, we;
  logic [31:0] addr, wdata;
  logic [3:0]  sel;
  logic        use_b;

  // ---------------- dut_a signals ----------------
  logic [31:0] rdata_a, sdo_a, sdi_a;
  logic        ack_a, soe_a, ce_n_a, oe_n_a, we_n_a;
  logic [19:0] saddr_a;
  logic [3:0]  be_n_a;
  logic [2:0]  dbg_a;

  // ---------------- dut_b signals ----------------
  logic [31:0] rdata_b, sdo_b, sdi_b;
  logic        ack_b, soe_b, ce_n_b, oe_n_b, we_n_b;
  logic [19:0] saddr_b;
  logic [3:0]  be_n_b;
  logic [2:0]  dbg_b;

  wishbone_sram_slave #(.ADDR_WIDTH(20), .READ_WAIT(2), .WRITE_WAIT(2)) dut_a (
    .clk(clk), .rst(rst),
    .wb_cyc_i(cyc_a), .wb_stb_i(stb), .wb_we_i(we),
    .wb_addr_i(addr), .wb_data_i(wdata), .wb_sel_i(sel),
    .wb_data_o(rdata_a), .wb_ack_o(ack_a),
    .sram_addr_o(saddr_a), .sram_data_i(sdi_a), .sram_data_o(sdo_a),
    .sram_data_oe(soe_a), .sram_ce_n(ce_n_a), .sram_oe_n(oe_n_a),
    .sram_we_n(we_n_a), .sram_be_n(be_n_a), .dbg_state(dbg_a)
  );

  wishbone_sram_slave #(.ADDR_WIDTH(20), .READ_WAIT(1), .WRITE_WAIT(1)) dut_b (
    .clk(clk), .rst(rst),
    .wb_cyc_i(cyc_b), .wb_stb_i(stb), .wb_we_i(we),
    .wb_addr_i(addr), .wb_data_i(wdata), .wb_sel_i(sel),
    .wb_data_o(rdata_b), .wb_ack_o(ack_b),
    .sram_addr_o(saddr_b), .sram_data_i(sdi_b), .sram_data_o(sdo_b),
    .sram_data_oe(soe_b), .sram_ce_n(ce_n_b), .sram_oe_n(oe_n_b),
    .sram_we_n(we_n_b), .sram_be_n(be_n_b), .dbg_state(dbg_b)
  );

  // Selected-DUT view used by the driver task
  logic        m_ack, m_oe_n, m_we_n;
  logic [31:0] m_rdata;
  logic [3:0]  m_be_n;
  logic [19:0] m_saddr;
  assign m_ack   = use_b ? ack_b   : ack_a;
  assign m_oe_n  = use_b ? oe_n_b  : oe_n_a;
  assign m_we_n  = use_b ? we_n_b  : we_n_a;
  assign m_rdata = use_b ? rdata_b : rdata_a;
  assign m_be_n  = use_b ? be_n_b  : be_n_a;
  assign m_saddr = use_b ? saddr_b : saddr_a;

  // ---------------- SRAM models (64 words each) ----------------
  logic [31:0] mem_a [64];
  logic [31:0] mem_b [64];

  function automatic logic [31:0] init_word(input int i);
    if (i == 16)      return 32'hDEADBEEF;
    else if (i == 32) return 32'h11223344;
    else              return 32'hC0DE0000 + 32'(i) * 32'h00010101;
  endfunction

  always @(posedge clk) begin
    if (mem_init) begin
      for (int i = 0; i < 64; i++) begin
        mem_a[i] <= init_word(i);
        mem_b[i] <= init_word(i);
      end
    end else begin
      if (!ce_n_a && !we_n_a && soe_a)
        for (int l = 0; l < 4; l++)
          if (!be_n_a[l]) mem_a[saddr_a[5:0]][8*l +: 8] <= sdo_a[8*l +: 8];
      if (!ce_n_b && !we_n_b && soe_b)
        for (int l = 0; l < 4; l++)
          if (!be_n_b[l]) mem_b[saddr_b[5:0]][8*l +: 8] <= sdo_b[8*l +: 8];
    end
  end

  assign sdi_a = (!ce_n_a && !oe_n_a) ? mem_a[saddr_a[5:0]] : 32'h0;
  assign sdi_b = (!ce_n_b && !oe_n_b) ? mem_b[saddr_b[5:0]] : 32'h0;

  // ---------------- scoreboard ----------------
  logic [31:0] ref_a [64];
  logic [31:0] ref_b [64];
  logic [31:0] exp_q [$];
  int          tests = 0;
  int          fails = 0;
  int          ack_cyc = 0;
  logic [31:0] last_rd_a = 32'h0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %h, expected %h", tag, got, exp);
    end
  endtask

  // One complete wishbone transfer on the selected DUT. keep=1 leaves
  // cyc/stb asserted after the ack so the next call continues the cycle.
  task automatic xfer(input bit is_b, input bit w, input logic [31:0] a,
                      input logic [31:0] d, input logic [3:0] s, input bit keep);
    int          wexp, edges, oe_low, we_low, both_low;
    logic [3:0]  be_seen, be_exp;
    logic [19:0] addr_seen;
    logic [31:0] e;
    wexp = is_b ? 1 : 2;
    edges = 0; oe_low = 0; we_low = 0; both_low = 0;
    be_seen = 4'h0; addr_seen = '0;
    be_exp = ~s;
    if (w) begin
      for (int l = 0; l < 4; l++)
        if (s[l]) begin
          if (is_b) ref_b[a[7:2]][8*l +: 8] = d[8*l +: 8];
          else      ref_a[a[7:2]][8*l +: 8] = d[8*l +: 8];
        end
    end else begin
      exp_q.push_back(is_b ? ref_b[a[7:2]] : ref_a[a[7:2]]);
    end
    @(negedge clk);
    use_b = is_b; cyc_a = !is_b; cyc_b = is_b; stb = 1'b1;
    we = w; addr = a; wdata = d; sel = s;
    do begin
      @(posedge clk); #1;
      edges++;
      if (!m_ack) begin
        if (!m_oe_n) oe_low++;
        if (!m_we_n) we_low++;
        if (edges == 1) begin be_seen = m_be_n; addr_seen = m_saddr; end
      end
      if (!m_oe_n && !m_we_n) both_low++;
    end while (!m_ack && edges < 20);
    ack_cyc = cyc_cnt;
    check("ack_latency", edges, wexp + 1);
    check(w ? "we_low_cycles" : "oe_low_cycles", w ? we_low : oe_low, wexp);
    check("idle_strobe_low", w ? oe_low : we_low, 0);
    check("oe_we_overlap", both_low, 0);
    check("sram_addr", 32'(addr_seen), 32'(a[21:2]));
    if (w) check("be_n", 32'(be_seen), 32'(be_exp));
    if (!w) begin
      e = exp_q.pop_front();
      check("rdata", m_rdata, e);
      if (!is_b) last_rd_a = e;
    end
    @(negedge clk);
    if (!keep) begin cyc_a = 1'b0; cyc_b = 1'b0; stb = 1'b0; end
    @(posedge clk); #1;
    check("ack_one_cycle", 32'(m_ack), 32'd0);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    int          a1, a2, acks;
    logic [31:0] ra;

    rst = 1'b1; mem_init = 1'b1; use_b = 1'b0;
    cyc_a = 1'b0; cyc_b = 1'b0; stb = 1'b0; we = 1'b0;
    addr = '0; wdata = '0; sel = '0;
    for (int i = 0; i < 64; i++) begin ref_a[i] = init_word(i); ref_b[i] = init_word(i); end
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0; mem_init = 1'b0;

    // Reset state
    check("rst_ack",     32'(ack_a),   32'd0);
    check("rst_rdata",   rdata_a,      32'h0);
    check("rst_addr",    32'(saddr_a), 32'h0);
    check("rst_sdo",     sdo_a,        32'h0);
    check("rst_data_oe", 32'(soe_a),   32'd0);
    check("rst_ce_n",    32'(ce_n_a),  32'd1);
    check("rst_oe_n",    32'(oe_n_a),  32'd1);
    check("rst_we_n",    32'(we_n_a),  32'd1);
    check("rst_be_n",    32'(be_n_a),  32'hF);
    check("rst_state",   32'(dbg_a),   32'd0);

    // Read of a preloaded word
    xfer(0, 0, 32'h40, 32'h0, 4'hF, 0);
    check("read_deadbeef", last_rd_a, 32'hDEADBEEF);

    // Single-lane write, then readback
    xfer(0, 1, 32'h80, 32'h00AB0000, 4'b0100, 0);
    xfer(0, 0, 32'h80, 32'h0, 4'hF, 0);
    check("lane_merge", last_rd_a, 32'h11AB3344);

    // Write then read with stb held high across the ack
    xfer(0, 1, 32'h30, 32'h5A5A1234, 4'hF, 1);
    a1 = ack_cyc;
    xfer(0, 0, 32'h30, 32'h0, 4'hF, 0);
    a2 = ack_cyc;
    check("ack_gap", 32'((a2 - a1) >= 2), 32'd1);
    check("b2b_readback", last_rd_a, 32'h5A5A1234);

    // sel=0 write completes and changes nothing
    xfer(0, 1, 32'h34, 32'hFFFFFFFF, 4'b0000, 0);
    xfer(0, 0, 32'h34, 32'h0, 4'hF, 0);

    // Abort in the second READ cycle
    ra = last_rd_a;
    @(negedge clk);
    use_b = 1'b0; cyc_a = 1'b1; stb = 1'b1; we = 1'b0; addr = 32'h44; sel = 4'hF;
    @(posedge clk); #1;
    @(posedge clk); #1;
    @(negedge clk);
    cyc_a = 1'b0; stb = 1'b0;
    @(posedge clk); #1;
    check("abort_ack",     32'(ack_a),  32'd0);
    check("abort_oe_n",    32'(oe_n_a), 32'd1);
    check("abort_ce_n",    32'(ce_n_a), 32'd1);
    check("abort_data_oe", 32'(soe_a),  32'd0);
    check("abort_rdata",   rdata_a,     ra);
    check("abort_state",   32'(dbg_a),  32'd0);
    acks = 0;
    repeat (4) begin @(posedge clk); #1; if (ack_a) acks++; end
    check("abort_no_late_ack", acks, 0);

    // Reset pulsed during WRITE
    @(negedge clk);
    use_b = 1'b0; cyc_a = 1'b1; stb = 1'b1; we = 1'b1;
    addr = 32'h48; wdata = 32'hCAFEF00D; sel = 4'hF;
    @(posedge clk); #1;
    check("write_we_low", 32'(we_n_a), 32'd0);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk); #1;
    check("rstw_we_n",    32'(we_n_a), 32'd1);
    check("rstw_data_oe", 32'(soe_a),  32'd0);
    check("rstw_ack",     32'(ack_a),  32'd0);
    check("rstw_ce_n",    32'(ce_n_a), 32'd1);
    check("rstw_be_n",    32'(be_n_a), 32'hF);
    @(negedge clk);
    rst = 1'b0; cyc_a = 1'b0; stb = 1'b0;
    last_rd_a = 32'h0;
    xfer(0, 1, 32'h48, 32'h12345678, 4'hF, 0);
    xfer(0, 0, 32'h48, 32'h0, 4'hF, 0);
    check("post_rst_readback", last_rd_a, 32'h12345678);

    // Single-wait build
    xfer(1, 1, 32'h50, 32'h0BADF00D, 4'b1001, 0);
    xfer(1, 0, 32'h50, 32'h0, 4'hF, 0);
    xfer(1, 0, 32'h40, 32'h0, 4'hF, 0);

    // Random traffic on dut_a
    for (int i = 0; i < 16; i++) begin
      xfer(0, 1'($urandom_range(0, 1)),
           (32'($urandom_range(0, 63)) << 2) | 32'($urandom_range(0, 3)),
           $urandom, 4'($urandom_range(0, 15)), 0);
    end
    for (int i = 0; i < 8; i++)
      xfer(0, 0, 32'($urandom_range(0, 63)) << 2, 32'h0, 4'hF, 0);

    check("scoreboard_empty", 32'(exp_q.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
